traffic_phase_scheduler: RTL and testbench



---
 rtl/traffic_pkg.sv | 29 ++
 rtl/tick_prescaler.sv | 35 +++
 rtl/traffic_phase_scheduler.sv | 158 +++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// ============================================================================
// Module      : traffic_pkg
// Description : Phase codes, phase type and default timing for the intersection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

  typedef enum logic [2:0] {
    GREEN_A   = 3'd0,
    YELLOW_A  = 3'd1,
    ALLRED_AB = 3'd2,
    GREEN_B   = 3'd3,
    YELLOW_B  = 3'd4,
    ALLRED_BA = 3'd5
  } phase_t;

  localparam int DEF_CLK_DIV   = 50_000_000;
  localparam int DEF_MIN_GREEN = 10;
  localparam int DEF_MAX_GREEN = 40;
  localparam int DEF_YELLOW_T  = 4;
  localparam int DEF_ALLRED_T  = 2;
  localparam int DEF_PED_WALK  = 8;
  localparam int DEF_TW        = 6;

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module      : tick_prescaler
// Description : Divides clk by CLK_DIV; tick is high for one cycle at the wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == C_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/traffic_phase_scheduler.sv
// ============================================================================
// Module      : traffic_phase_scheduler
// Description : Tick-driven phase sequencer arbitrating streets A/B and pedestrians.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int MIN_GREEN = DEF_MIN_GREEN,
  parameter int MAX_GREEN = DEF_MAX_GREEN,
  parameter int YELLOW_T  = DEF_YELLOW_T,
  parameter int ALLRED_T  = DEF_ALLRED_T,
  parameter int PED_WALK  = DEF_PED_WALK,
  parameter int TW        = DEF_TW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Sa,
  input  logic          Sb,
  input  logic          Pa_btn,
  input  logic          Pb_btn,
  output logic          step,
  output logic [2:0]    phase,
  output logic          walk_a,
  output logic          walk_b,
  output logic [1:0]    req_pend,
  output logic [TW-1:0] dwell
);

  // Dwell comparisons run one bit wider so dwell+1 never wraps at saturation.
  localparam logic [TW:0]   C_ONE   = (TW+1)'(1);
  localparam logic [TW:0]   C_MIN_G = (TW+1)'(MIN_GREEN);
  localparam logic [TW:0]   C_MAX_G = (TW+1)'(MAX_GREEN);
  localparam logic [TW:0]   C_YEL   = (TW+1)'(YELLOW_T);
  localparam logic [TW:0]   C_ALLR  = (TW+1)'(ALLRED_T);
  localparam logic [TW-1:0] C_WALK  = TW'(PED_WALK);

  logic          tick;
  logic [1:0]    r_sa_sync, r_sb_sync, r_pa_sync, r_pb_sync;
  logic          r_pa_prev, r_pb_prev;
  phase_t        r_phase, w_phase_nx;
  logic [TW-1:0] r_dwell;
  logic          r_step;
  logic [1:0]    r_req;
  logic          r_walk_a_en, r_walk_b_en;
  logic [TW:0]   w_d1;
  logic          w_change, w_enter_ga, w_enter_gb;
  logic          w_sa, w_sb, w_pa_edge, w_pb_edge, w_demand_a, w_demand_b;

  tick_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sa_sync <= '0;
      r_sb_sync <= '0;
      r_pa_sync <= '0;
      r_pb_sync <= '0;
      r_pa_prev <= 1'b0;
      r_pb_prev <= 1'b0;
    end else begin
      r_sa_sync <= {r_sa_sync[0], Sa};
      r_sb_sync <= {r_sb_sync[0], Sb};
      r_pa_sync <= {r_pa_sync[0], Pa_btn};
      r_pb_sync <= {r_pb_sync[0], Pb_btn};
      r_pa_prev <= r_pa_sync[1];
      r_pb_prev <= r_pb_sync[1];
    end
  end

  assign w_sa       = r_sa_sync[1];
  assign w_sb       = r_sb_sync[1];
  assign w_pa_edge  = r_pa_sync[1] & ~r_pa_prev;
  assign w_pb_edge  = r_pb_sync[1] & ~r_pb_prev;
  // A pedestrian crossing street A is served while A is red, i.e. in GREEN_B.
  assign w_demand_b = w_sb | r_req[0];
  assign w_demand_a = w_sa | r_req[1];
  assign w_d1       = {1'b0, r_dwell} + C_ONE;

  always_comb begin
    w_phase_nx = r_phase;
    case (r_phase)
      GREEN_A: begin
        if (tick && (w_d1 >= C_MIN_G) && w_demand_b && (!w_sa || (w_d1 >= C_MAX_G)))
          w_phase_nx = YELLOW_A;
      end
      YELLOW_A: begin
        if (tick && (w_d1 >= C_YEL)) w_phase_nx = ALLRED_AB;
      end
      ALLRED_AB: begin
        if (tick && (w_d1 >= C_ALLR)) w_phase_nx = GREEN_B;
      end
      GREEN_B: begin
        // A is the rest phase: B also yields at minimum green once its demand is gone.
        if (tick && (w_d1 >= C_MIN_G) &&
            (!w_demand_b || (w_demand_a && (!w_sb || (w_d1 >= C_MAX_G)))))
          w_phase_nx = YELLOW_B;
      end
      YELLOW_B: begin
        if (tick && (w_d1 >= C_YEL)) w_phase_nx = ALLRED_BA;
      end
      ALLRED_BA: begin
        if (tick && (w_d1 >= C_ALLR)) w_phase_nx = GREEN_A;
      end
      default: w_phase_nx = GREEN_A;
    endcase
  end

  assign w_change   = (w_phase_nx != r_phase);
  assign w_enter_ga = w_change && (w_phase_nx == GREEN_A);
  assign w_enter_gb = w_change && (w_phase_nx == GREEN_B);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase <= GREEN_A;
      r_dwell <= '0;
      r_step  <= 1'b0;
    end else if (w_change) begin
      r_phase <= w_phase_nx;
      r_dwell <= '0;
      r_step  <= 1'b1;
    end else begin
      r_step <= 1'b0;
      if (tick && !(&r_dwell)) r_dwell <= r_dwell + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req       <= '0;
      r_walk_a_en <= 1'b0;
      r_walk_b_en <= 1'b0;
    end else begin
      r_req[0] <= w_pa_edge | (r_req[0] & ~w_enter_gb);
      r_req[1] <= w_pb_edge | (r_req[1] & ~w_enter_ga);
      if (w_enter_gb) r_walk_a_en <= r_req[0];
      if (w_enter_ga) r_walk_b_en <= r_req[1];
    end
  end

  assign step     = r_step;
  assign phase    = r_phase;
  assign dwell    = r_dwell;
  assign req_pend = r_req;
  assign walk_a   = (r_phase == GREEN_B) && r_walk_a_en && (r_dwell < C_WALK);
  assign walk_b   = (r_phase == GREEN_A) && r_walk_b_en && (r_dwell < C_WALK);

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
// ============================================================================
// Module      : tb_traffic_phase_scheduler
// Description : Scoreboard bench; expected step events are queued, a monitor checks them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_phase_scheduler;

  localparam int TW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          Sa = 1'b0, Sb = 1'b0, Pa_btn = 1'b0, Pb_btn = 1'b0;
  logic          step;
  logic [2:0]    phase;
  logic          walk_a, walk_b;
  logic [1:0]    req_pend;
  logic [TW-1:0] dwell;

  traffic_phase_scheduler #(
    .CLK_DIV(4), .MIN_GREEN(3), .MAX_GREEN(6), .YELLOW_T(2),
    .ALLRED_T(1), .PED_WALK(2), .TW(TW)
  ) dut (
    .clk(clk), .reset(reset), .Sa(Sa), .Sb(Sb), .Pa_btn(Pa_btn), .Pb_btn(Pb_btn),
    .step(step), .phase(phase), .walk_a(walk_a), .walk_b(walk_b),
    .req_pend(req_pend), .dwell(dwell)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; tick k lands on edge 4k.
  int e;
  always @(posedge clk or negedge reset) begin
    if (!reset) e <= 0;
    else        e <= e + 1;
  end

  typedef struct packed {
    logic [2:0]  ph;
    logic [1:0]  rp;
    logic        wa;
    logic        wb;
    logic [15:0] tk;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic prev_step = 1'b0;

  always @(negedge clk) begin
    exp_t act, x;
    if (!reset) begin
      prev_step <= 1'b0;
    end else begin
      if (step) begin
        checks++;
        act = '{ph: phase, rp: req_pend, wa: walk_a, wb: walk_b, tk: 16'(e / 4)};
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_step: got phase=%0d req=%b wa=%b wb=%b tick=%0d, expected no step",
                   act.ph, act.rp, act.wa, act.wb, act.tk);
        end else begin
          x = q.pop_front();
          if (act !== x || prev_step || (e % 4) != 0) begin
            errors++;
            $display("FAIL step_event: got phase=%0d req=%b wa=%b wb=%b tick=%0d edge=%0d back2back=%b, expected phase=%0d req=%b wa=%b wb=%b tick=%0d",
                     act.ph, act.rp, act.wa, act.wb, act.tk, e, prev_step,
                     x.ph, x.rp, x.wa, x.wb, x.tk);
          end
        end
      end
      prev_step <= step;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] ph, input logic [1:0] rp, input logic wa,
                      input logic wb, input int tk);
    q.push_back('{ph: ph, rp: rp, wa: wa, wb: wb, tk: 16'(tk)});
  endtask

  task automatic at_edge(input int n);
    wait (e >= n);
    @(negedge clk);
  endtask

  task automatic restart(input logic sa, input logic sb);
    reset = 1'b0;
    Sa = sa; Sb = sb; Pa_btn = 1'b0; Pb_btn = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk(name, q.size(), 0);
    q.delete();
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_phase", phase, 0);
    chk("rst_dwell", dwell, 0);
    chk("rst_step", step, 0);
    chk("rst_walk", {walk_a, walk_b}, 0);
    chk("rst_req", req_pend, 0);

    // Idle: rests in GREEN_A, dwell saturates
    reset = 1'b1;
    at_edge(400);
    chk("idle_phase", phase, 0);
    chk("idle_dwell_sat", dwell, 63);
    chk("idle_step", step, 0);

    // Street B demand, then released
    restart(1'b0, 1'b1);
    push(3'd1, 2'b00, 0, 0, 3);
    push(3'd2, 2'b00, 0, 0, 5);
    push(3'd3, 2'b00, 0, 0, 6);
    push(3'd4, 2'b00, 0, 0, 9);
    push(3'd5, 2'b00, 0, 0, 11);
    push(3'd0, 2'b00, 0, 0, 12);
    at_edge(25);
    Sb = 1'b0;
    drain("sb_seq_done");
    at_edge(60);
    chk("sb_rest_phase", phase, 0);

    // Both streets busy: MAX_GREEN cap, period 18 ticks
    restart(1'b1, 1'b1);
    for (int c = 0; c < 2; c++) begin
      push(3'd1, 2'b00, 0, 0, 18*c + 6);
      push(3'd2, 2'b00, 0, 0, 18*c + 8);
      push(3'd3, 2'b00, 0, 0, 18*c + 9);
      push(3'd4, 2'b00, 0, 0, 18*c + 15);
      push(3'd5, 2'b00, 0, 0, 18*c + 17);
      push(3'd0, 2'b00, 0, 0, 18*c + 18);
    end
    drain("maxgreen_done");

    // Pedestrian A press at tick 1
    restart(1'b0, 1'b0);
    push(3'd1, 2'b01, 0, 0, 3);
    push(3'd2, 2'b01, 0, 0, 5);
    push(3'd3, 2'b00, 1, 0, 6);
    push(3'd4, 2'b00, 0, 0, 9);
    push(3'd5, 2'b00, 0, 0, 11);
    push(3'd0, 2'b00, 0, 0, 12);
    at_edge(4);  Pa_btn = 1'b1;
    at_edge(5);  Pa_btn = 1'b0;
    at_edge(8);  chk("pa_latched", req_pend, 2'b01);
    at_edge(29); chk("walk_a_dwell1", walk_a, 1);
    at_edge(33); chk("walk_a_dwell2", walk_a, 0);
    drain("ped_a_done");

    // Asynchronous reset during YELLOW_B with both requests pending
    restart(1'b0, 1'b0);
    push(3'd1, 2'b11, 0, 0, 3);
    push(3'd2, 2'b11, 0, 0, 5);
    push(3'd3, 2'b10, 1, 0, 6);
    push(3'd4, 2'b11, 0, 0, 9);
    at_edge(4);  Pa_btn = 1'b1; Pb_btn = 1'b1;
    at_edge(5);  Pa_btn = 1'b0; Pb_btn = 1'b0;
    at_edge(25); Pa_btn = 1'b1;
    at_edge(26); Pa_btn = 1'b0;
    at_edge(38);
    chk("yb_phase_pre", phase, 4);
    chk("yb_req_pre", req_pend, 2'b11);
    chk("yb_queue_empty", q.size(), 0);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_phase", phase, 0);
    chk("async_rst_dwell", dwell, 0);
    chk("async_rst_req", req_pend, 0);
    chk("async_rst_step_walk", {step, walk_a, walk_b}, 0);
    Sb = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    push(3'd1, 2'b00, 0, 0, 3);
    drain("restart_done");

    // Pb edge coincides with GREEN_A entry
    restart(1'b0, 1'b1);
    push(3'd1, 2'b00, 0, 0, 3);
    push(3'd2, 2'b00, 0, 0, 5);
    push(3'd3, 2'b00, 0, 0, 6);
    push(3'd4, 2'b00, 0, 0, 9);
    push(3'd5, 2'b00, 0, 0, 11);
    push(3'd0, 2'b10, 0, 0, 12);
    at_edge(25); Sb = 1'b0;
    at_edge(45); Pb_btn = 1'b1;
    at_edge(46); Pb_btn = 1'b0;
    at_edge(49);
    chk("pb_same_cycle_req", req_pend, 2'b10);
    chk("pb_same_cycle_walk", walk_b, 0);
    at_edge(53);
    chk("pb_walk_b_later", walk_b, 0);
    drain("pb_edge_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
